// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter: FSM state encoding,
// default sizing and the grant-pointer width helper.
package div_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    ZERO  = 3'd3,
    RESP  = 3'd4
  } arb_state_t;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_TIMEOUT = 64;

  // Keeps the pointer at least one bit wide for the degenerate single-requester case.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/divider_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr,
// wrapping modulo N_REQ. The pointer register lives in the parent.
module rr_arbiter
  import div_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int PTR_W = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any_grant
);

  logic [PTR_W-1:0] idx_s;

  // Scan from the pointer upward; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx_s     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_s = PTR_W'((int'(rr_ptr) + i) % N_REQ);
      if (!any_grant && req_valid[idx_s]) begin
        grant[idx_s] = 1'b1;
        grant_idx    = idx_s;
        any_grant    = 1'b1;
      end else begin
        any_grant = any_grant;
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one iterative divider between N_REQ requesters with round-robin grants
// and a divide-by-zero short circuit. Define DIV_ARB_TIMEOUT_EN for a WAIT watchdog.
module divider_arbiter
  import div_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [N_REQ-1:0]       req_valid_in,
  output logic [N_REQ-1:0]       req_ready_out,
  input  logic [N_REQ*WIDTH-1:0] req_dividend_in,
  input  logic [N_REQ*WIDTH-1:0] req_divisor_in,
  output logic [N_REQ-1:0]       resp_valid_out,
  output logic [WIDTH-1:0]       resp_quotient_out,
  output logic [WIDTH-1:0]       resp_remainder_out,
  output logic                   resp_error_out,
  output logic [WIDTH-1:0]       div_dividend_out,
  output logic [WIDTH-1:0]       div_divisor_out,
  output logic                   div_start_out,
  input  logic [WIDTH-1:0]       div_quotient_in,
  input  logic [WIDTH-1:0]       div_remainder_in,
  input  logic                   div_valid_in,
  input  logic                   div_error_in,
  input  logic                   div_busy_in
);

  localparam int PTR_W = ptr_width(N_REQ);

  arb_state_t       state_r, state_nx;
  logic [PTR_W-1:0] rr_ptr_r, rr_ptr_nx;
  logic [PTR_W-1:0] owner_r, owner_nx;
  logic [WIDTH-1:0] dividend_r, dividend_nx;
  logic [WIDTH-1:0] divisor_r, divisor_nx;
  logic [WIDTH-1:0] quot_r, quot_nx;
  logic [WIDTH-1:0] rem_r, rem_nx;
  logic             err_r, err_nx;
  logic             start_r, start_nx;
  logic [N_REQ-1:0] resp_valid_r, resp_valid_nx;
  logic [N_REQ-1:0] ready_s;
  logic [N_REQ-1:0] grant_s;
  logic [PTR_W-1:0] grant_idx_s;
  logic             grant_any_s;

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_r, cnt_nx;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req_valid (req_valid_in),
    .rr_ptr    (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any_grant (grant_any_s)
  );

  // Next-state, operand capture and result selection.
  always_comb begin
    state_nx      = state_r;
    rr_ptr_nx     = rr_ptr_r;
    owner_nx      = owner_r;
    dividend_nx   = dividend_r;
    divisor_nx    = divisor_r;
    quot_nx       = quot_r;
    rem_nx        = rem_r;
    err_nx        = err_r;
    start_nx      = 1'b0;
    resp_valid_nx = '0;
    ready_s       = '0;
`ifdef DIV_ARB_TIMEOUT_EN
    cnt_nx = (state_r == WAIT) ? cnt_r + CNT_W'(1) : '0;
`endif
    case (state_r)
      IDLE: begin
        if (grant_any_s && !div_busy_in) begin
          ready_s     = grant_s;
          owner_nx    = grant_idx_s;
          rr_ptr_nx   = (grant_idx_s == PTR_W'(N_REQ - 1)) ? '0 : grant_idx_s + PTR_W'(1);
          dividend_nx = req_dividend_in[int'(grant_idx_s)*WIDTH +: WIDTH];
          divisor_nx  = req_divisor_in[int'(grant_idx_s)*WIDTH +: WIDTH];
          if (divisor_nx == '0) begin
            state_nx = ZERO;
          end else begin
            state_nx = ISSUE;
            start_nx = 1'b1;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (div_valid_in) begin
          quot_nx  = div_quotient_in;
          rem_nx   = div_remainder_in;
          err_nx   = div_error_in;
          state_nx = RESP;
          resp_valid_nx[owner_r] = 1'b1;
        end
`ifdef DIV_ARB_TIMEOUT_EN
        // Divider went silent: report a failed divide instead of hanging the owner.
        else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          quot_nx  = '0;
          rem_nx   = '0;
          err_nx   = 1'b1;
          state_nx = RESP;
          resp_valid_nx[owner_r] = 1'b1;
        end
`endif
        else begin
          state_nx = WAIT;
        end
      end
      ZERO: begin
        quot_nx  = '1;
        rem_nx   = dividend_r;
        err_nx   = 1'b1;
        state_nx = RESP;
        resp_valid_nx[owner_r] = 1'b1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r      <= IDLE;
      rr_ptr_r     <= '0;
      owner_r      <= '0;
      dividend_r   <= '0;
      divisor_r    <= '0;
      quot_r       <= '0;
      rem_r        <= '0;
      err_r        <= 1'b0;
      start_r      <= 1'b0;
      resp_valid_r <= '0;
`ifdef DIV_ARB_TIMEOUT_EN
      cnt_r        <= '0;
`endif
    end else begin
      state_r      <= state_nx;
      rr_ptr_r     <= rr_ptr_nx;
      owner_r      <= owner_nx;
      dividend_r   <= dividend_nx;
      divisor_r    <= divisor_nx;
      quot_r       <= quot_nx;
      rem_r        <= rem_nx;
      err_r        <= err_nx;
      start_r      <= start_nx;
      resp_valid_r <= resp_valid_nx;
`ifdef DIV_ARB_TIMEOUT_EN
      cnt_r        <= cnt_nx;
`endif
    end
  end

  // Ready is combinational by nature; force it low while reset is asserted.
  assign req_ready_out      = rst_n_in ? ready_s : '0;
  assign resp_valid_out     = resp_valid_r;
  assign resp_quotient_out  = quot_r;
  assign resp_remainder_out = rem_r;
  assign resp_error_out     = err_r;
  assign div_dividend_out   = dividend_r;
  assign div_divisor_out    = divisor_r;
  assign div_start_out      = start_r;

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter (N_REQ=2, WIDTH=32) with a behavioural
// divider stub driven from the stimulus sequence.
module tb_divider_arbiter;

  localparam int N = 2;
  localparam int W = 32;

  logic           clk_in = 1'b0;
  logic           rst_n_in = 1'b0;
  logic [N-1:0]   req_valid_in = '0;
  logic [N-1:0]   req_ready_out;
  logic [N*W-1:0] req_dividend_in = '0;
  logic [N*W-1:0] req_divisor_in = '0;
  logic [N-1:0]   resp_valid_out;
  logic [W-1:0]   resp_quotient_out;
  logic [W-1:0]   resp_remainder_out;
  logic           resp_error_out;
  logic [W-1:0]   div_dividend_out;
  logic [W-1:0]   div_divisor_out;
  logic           div_start_out;
  logic [W-1:0]   div_quotient_in = '0;
  logic [W-1:0]   div_remainder_in = '0;
  logic           div_valid_in = 1'b0;
  logic           div_error_in = 1'b0;
  logic           div_busy_in = 1'b0;

  int checks = 0;
  int errors = 0;

  divider_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_dividend_in(req_dividend_in), .req_divisor_in(req_divisor_in),
    .resp_valid_out(resp_valid_out), .resp_quotient_out(resp_quotient_out),
    .resp_remainder_out(resp_remainder_out), .resp_error_out(resp_error_out),
    .div_dividend_out(div_dividend_out), .div_divisor_out(div_divisor_out),
    .div_start_out(div_start_out), .div_quotient_in(div_quotient_in),
    .div_remainder_in(div_remainder_in), .div_valid_in(div_valid_in),
    .div_error_in(div_error_in), .div_busy_in(div_busy_in)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_dividend_in[i*W +: W] = a;
    req_divisor_in[i*W +: W]  = b;
  endtask

  // Divider stub: called in the ISSUE cycle, returns its result lat cycles later.
  task automatic div_model(input int lat, input logic [W-1:0] q, input logic [W-1:0] r,
                           input logic e);
    int st;
    int rs;
    st = 0;
    rs = 0;
    div_busy_in = 1'b1;
    for (int k = 0; k < lat - 1; k++) begin
      step();
      st += int'(div_start_out);
      rs += int'(|resp_valid_out);
    end
    div_quotient_in  = q;
    div_remainder_in = r;
    div_error_in     = e;
    div_valid_in     = 1'b1;
    step();
    div_valid_in = 1'b0;
    div_busy_in  = 1'b0;
    chk("extra_start", W'(st), 32'd0);
    chk("early_resp", W'(rs), 32'd0);
  endtask

  initial begin
    int rs;
    #2;
    chk("rst_ready", W'(req_ready_out), 32'd0);
    chk("rst_resp", W'(resp_valid_out), 32'd0);
    chk("rst_start", W'(div_start_out), 32'd0);
    chk("rst_quot", resp_quotient_out, 32'd0);
    chk("rst_dividend", div_dividend_out, 32'd0);
    repeat (2) step();
    rst_n_in = 1'b1;
    step();

    // Contention: both requesters hold valid, grants rotate 0,1,0
    set_req(0, 32'd1000, 32'd3);
    set_req(1, 32'd77, 32'd7);
    req_valid_in = 2'b11;
    #1;
    chk("grant1_ready", W'(req_ready_out), 32'd1);
    step();
    chk("grant1_start", W'(div_start_out), 32'd1);
    chk("grant1_dividend", div_dividend_out, 32'd1000);
    chk("grant1_divisor", div_divisor_out, 32'd3);
    chk("issue_no_ready", W'(req_ready_out), 32'd0);
    div_model(33, 32'd333, 32'd1, 1'b0);
    chk("c1_resp", W'(resp_valid_out), 32'd1);
    chk("c1_quot", resp_quotient_out, 32'd333);
    chk("c1_rem", resp_remainder_out, 32'd1);
    chk("c1_err", W'(resp_error_out), 32'd0);
    chk("resp_no_ready", W'(req_ready_out), 32'd0);
    step();
    chk("c1_resp_end", W'(resp_valid_out), 32'd0);
    chk("grant2_ready", W'(req_ready_out), 32'd2);
    step();
    chk("grant2_start", W'(div_start_out), 32'd1);
    chk("grant2_dividend", div_dividend_out, 32'd77);
    div_model(5, 32'd11, 32'd0, 1'b0);
    chk("c2_resp", W'(resp_valid_out), 32'd2);
    chk("c2_quot", resp_quotient_out, 32'd11);
    chk("c2_rem", resp_remainder_out, 32'd0);
    step();
    chk("grant3_ready", W'(req_ready_out), 32'd1);
    step();
    req_valid_in = 2'b00;
    chk("grant3_dividend", div_dividend_out, 32'd1000);
    div_model(4, 32'd333, 32'd1, 1'b0);
    chk("c3_resp", W'(resp_valid_out), 32'd1);
    step();

    // Single request 1000/8, latency 33
    set_req(0, 32'd1000, 32'd8);
    req_valid_in = 2'b01;
    #1;
    chk("s_ready", W'(req_ready_out), 32'd1);
    step();
    req_valid_in = 2'b00;
    chk("s_start", W'(div_start_out), 32'd1);
    chk("s_divisor", div_divisor_out, 32'd8);
    div_model(33, 32'd125, 32'd0, 1'b0);
    chk("s_resp", W'(resp_valid_out), 32'd1);
    chk("s_quot", resp_quotient_out, 32'd125);
    chk("s_rem", resp_remainder_out, 32'd0);
    chk("s_err", W'(resp_error_out), 32'd0);
    step();
    chk("s_resp_end", W'(resp_valid_out), 32'd0);

    // Divide by zero on requester 1: 50/0
    set_req(1, 32'd50, 32'd0);
    req_valid_in = 2'b10;
    #1;
    chk("z_ready", W'(req_ready_out), 32'd2);
    step();
    req_valid_in = 2'b00;
    chk("z_no_start", W'(div_start_out), 32'd0);
    chk("z_resp_early", W'(resp_valid_out), 32'd0);
    step();
    chk("z_resp", W'(resp_valid_out), 32'd2);
    chk("z_quot", resp_quotient_out, 32'hFFFF_FFFF);
    chk("z_rem", resp_remainder_out, 32'd50);
    chk("z_err", W'(resp_error_out), 32'd1);
    chk("z_no_start2", W'(div_start_out), 32'd0);
    step();
    chk("z_resp_end", W'(resp_valid_out), 32'd0);

    // Busy gating: no grant while the divider reports busy
    div_busy_in = 1'b1;
    set_req(0, 32'd9, 32'd2);
    req_valid_in = 2'b01;
    #1;
    chk("b_blocked", W'(req_ready_out), 32'd0);
    step();
    chk("b_blocked2", W'(req_ready_out), 32'd0);
    div_busy_in = 1'b0;
    #1;
    chk("b_ready", W'(req_ready_out), 32'd1);
    step();
    req_valid_in = 2'b00;
    chk("b_start", W'(div_start_out), 32'd1);
    div_model(3, 32'd4, 32'd1, 1'b0);
    chk("b_resp", W'(resp_valid_out), 32'd1);
    chk("b_quot", resp_quotient_out, 32'd4);
    chk("b_rem", resp_remainder_out, 32'd1);
    step();

    // Reset while waiting on the divider
    set_req(0, 32'd100, 32'd10);
    req_valid_in = 2'b01;
    #1;
    step();
    req_valid_in = 2'b00;
    div_busy_in = 1'b1;
    step();
    step();
    set_req(1, 32'd84, 32'd4);
    req_valid_in = 2'b10;
    rst_n_in = 1'b0;
    #1;
    chk("r_ready", W'(req_ready_out), 32'd0);
    chk("r_resp", W'(resp_valid_out), 32'd0);
    chk("r_quot", resp_quotient_out, 32'd0);
    chk("r_rem", resp_remainder_out, 32'd0);
    chk("r_err", W'(resp_error_out), 32'd0);
    chk("r_start", W'(div_start_out), 32'd0);
    chk("r_dividend", div_dividend_out, 32'd0);
    chk("r_divisor", div_divisor_out, 32'd0);
    step();
    rst_n_in = 1'b1;
    req_valid_in = 2'b00;
    div_quotient_in = 32'd10;
    div_valid_in = 1'b1;
    step();
    div_valid_in = 1'b0;
    div_busy_in = 1'b0;
    chk("r_late_resp", W'(resp_valid_out), 32'd0);
    step();
    chk("r_late_resp2", W'(resp_valid_out), 32'd0);
    req_valid_in = 2'b10;
    #1;
    chk("r_new_ready", W'(req_ready_out), 32'd2);
    step();
    req_valid_in = 2'b00;
    chk("r_new_dividend", div_dividend_out, 32'd84);
    div_model(6, 32'd21, 32'd0, 1'b0);
    chk("r_new_resp", W'(resp_valid_out), 32'd2);
    chk("r_new_quot", resp_quotient_out, 32'd21);
    step();

`ifdef DIV_ARB_TIMEOUT_EN
    // Watchdog: divider never answers, RESP comes 16 cycles after entering WAIT
    set_req(0, 32'd7, 32'd1);
    req_valid_in = 2'b01;
    #1;
    step();
    req_valid_in = 2'b00;
    chk("t_start", W'(div_start_out), 32'd1);
    div_busy_in = 1'b1;
    step();
    rs = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      rs += int'(|resp_valid_out);
    end
    chk("t_early_resp", W'(rs), 32'd0);
    step();
    chk("t_resp", W'(resp_valid_out), 32'd1);
    chk("t_quot", resp_quotient_out, 32'd0);
    chk("t_rem", resp_remainder_out, 32'd0);
    chk("t_err", W'(resp_error_out), 32'd1);
    step();
    div_quotient_in = 32'd3;
    div_valid_in = 1'b1;
    step();
    div_valid_in = 1'b0;
    div_busy_in = 1'b0;
    chk("t_stray", W'(resp_valid_out), 32'd0);
    step();
    chk("t_stray2", W'(resp_valid_out), 32'd0);
`else
    rs = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
